// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_ctrl_pkg
// Purpose  : Shared definitions for the LED scan sequencer: MODE encodings,
//            controller state enum and the scan-advance helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_PING   = 2'b11;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic       dir_up;
        logic [2:0] pos;
    } scan_pos_t;

    // Next scan position. Up/down wrap through the 3-bit range. Ping-pong
    // turns around on the end value itself, so 7 and 0 each dwell one step.
    function automatic scan_pos_t scan_advance(input logic [1:0] mode,
                                               input scan_pos_t cur);
        scan_pos_t nxt;
        nxt = cur;
        if (mode == MODE_PING) begin
            if (cur.dir_up) begin
                if (cur.pos == 3'd7) begin
                    nxt.pos    = 3'd6;
                    nxt.dir_up = 1'b0;
                end else begin
                    nxt.pos = cur.pos + 3'd1;
                end
            end else begin
                if (cur.pos == 3'd0) begin
                    nxt.pos    = 3'd1;
                    nxt.dir_up = 1'b1;
                end else begin
                    nxt.pos = cur.pos - 3'd1;
                end
            end
        end else if (cur.dir_up) begin
            nxt.pos = cur.pos + 3'd1;
        end else begin
            nxt.pos = cur.pos - 3'd1;
        end
        return nxt;
    endfunction

endpackage : led_ctrl_pkg
`default_nettype wire

// File: rtl/step_tick.sv
`default_nettype none
// ============================================================================
// Module   : step_tick
// Purpose  : Scan-step prescaler. Counts 0..STEP_DIV-1 while enabled and
//            flags the terminal count. Clear has priority over enable;
//            when neither is active the count is frozen.
// Ports    : clk_i  - clock
//            rst_i  - synchronous active-high reset
//            clr_i  - force count to 0 (suppresses tick)
//            en_i   - advance count
//            tick_o - high while enabled at terminal count
// Revision : 1.0 - initial release
// ============================================================================
module step_tick #(
    parameter int unsigned STEP_DIV = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned    CW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          w_last;

    assign w_last = (cnt_q == C_LAST);
    assign tick_o = en_i & ~clr_i & w_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = w_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : step_tick
`default_nettype wire

// File: rtl/led_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_ctrl
// Purpose  : Sequencer for an 8-LED one-hot bank. Selects the LED code from
//            the switches (manual) or a timed scan (up, down, ping-pong)
//            with a push-button pause. All outputs registered.
// Ports    : clk_i        - board clock
//            rst_i        - synchronous active-high reset
//            sw0_i..sw2_i - manual code {sw2,sw1,sw0}
//            mode_i       - 00 manual, 01 up, 10 down, 11 ping-pong
//            btn_pause_i  - debounced level; rising edge toggles pause
//            sel_o        - current LED code
//            led_o        - one-hot of sel_o
//            step_o       - one-cycle pulse when the scan advances
//            paused_o     - high while the scan is held
// Revision : 1.0 - initial release
// ============================================================================
module led_scan_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned STEP_DIV = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sw0_i,
    input  logic       sw1_i,
    input  logic       sw2_i,
    input  logic [1:0] mode_i,
    input  logic       btn_pause_i,
    output logic [2:0] sel_o,
    output logic [7:0] led_o,
    output logic       step_o,
    output logic       paused_o
);

    logic [1:0] mode_q;
    logic       btn_q;
    state_e     state_q,  state_d;
    logic [2:0] sel_q,    sel_d;
    logic       dir_up_q, dir_up_d;
    logic [7:0] led_q,    led_d;
    logic       step_q,   step_d;
    logic       paused_q, paused_d;

    logic [2:0] w_sw;
    logic       w_mode_chg;
    logic       w_pause_edge;
    logic       w_tick;
    logic       w_tick_clr;
    logic       w_tick_en;
    scan_pos_t  w_next;

    assign w_sw         = {sw2_i, sw1_i, sw0_i};
    assign w_mode_chg   = (mode_i != mode_q);
    assign w_pause_edge = btn_pause_i & ~btn_q;

    // Prescaler runs only in RUN; it is held at 0 in MANUAL and restarted on
    // every mode change, and simply frozen in HOLD so resume keeps the phase.
    assign w_tick_clr = w_mode_chg | (state_q == ST_MANUAL);
    assign w_tick_en  = (state_q == ST_RUN);

    step_tick #(
        .STEP_DIV (STEP_DIV)
    ) u_step_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_tick_clr),
        .en_i   (w_tick_en),
        .tick_o (w_tick)
    );

    assign w_next = scan_advance(mode_q, '{dir_up: dir_up_q, pos: sel_q});

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        dir_up_d = dir_up_q;
        step_d   = 1'b0;
        paused_d = paused_q;

        // A mode change overrides any tick or pause edge in the same cycle.
        if (w_mode_chg) begin
            sel_d    = w_sw;
            paused_d = 1'b0;
            if (mode_i == MODE_MANUAL) begin
                state_d = ST_MANUAL;
            end else begin
                state_d  = ST_RUN;
                dir_up_d = (mode_i != MODE_DOWN);
            end
        end else begin
            case (state_q)
                ST_MANUAL: begin
                    sel_d    = w_sw;
                    paused_d = 1'b0;
                end
                ST_RUN: begin
                    // A tick coinciding with a pause edge still steps.
                    if (w_tick) begin
                        sel_d    = w_next.pos;
                        dir_up_d = w_next.dir_up;
                        step_d   = 1'b1;
                    end
                    if (w_pause_edge) begin
                        state_d  = ST_HOLD;
                        paused_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_pause_edge) begin
                        state_d  = ST_RUN;
                        paused_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = ST_MANUAL;
                    paused_d = 1'b0;
                end
            endcase
        end

        // Decode from the next code so LED and SEL update on the same edge.
        led_d = 8'b0000_0001 << sel_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q   <= MODE_MANUAL;
            btn_q    <= 1'b0;
            state_q  <= ST_MANUAL;
            sel_q    <= 3'd0;
            dir_up_q <= 1'b1;
            led_q    <= 8'h01;
            step_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            mode_q   <= mode_i;
            btn_q    <= btn_pause_i;
            state_q  <= state_d;
            sel_q    <= sel_d;
            dir_up_q <= dir_up_d;
            led_q    <= led_d;
            step_q   <= step_d;
            paused_q <= paused_d;
        end
    end

    assign sel_o    = sel_q;
    assign led_o    = led_q;
    assign step_o   = step_q;
    assign paused_o = paused_q;

endmodule : led_scan_ctrl
`default_nettype wire

// File: tb/tb_led_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_scan_ctrl
// Purpose  : Self-checking bench for led_scan_ctrl (STEP_DIV=4). Directed
//            scenarios followed by randomized traffic, every cycle compared
//            against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_scan_ctrl;

    localparam int unsigned STEP_DIV = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       btn  = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] sw   = 3'd0;

    logic [2:0] sel;
    logic [7:0] led;
    logic       step;
    logic       paused;

    int tests = 0;
    int fails = 0;

    // Reference model: positions as plain integers; ping-pong follows a
    // 14-entry bounce cycle indexed by m_k.
    int m_mode_prev = 0;
    int m_pos       = 0;
    int m_elapsed   = 0;
    int m_k         = 0;
    bit m_btn_prev  = 1'b0;
    bit m_manual    = 1'b1;
    bit m_paused    = 1'b0;
    bit m_step      = 1'b0;

    int s3_seq [15] = '{2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

    always #5 clk = ~clk;

    led_scan_ctrl #(
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sw0_i       (sw[0]),
        .sw1_i       (sw[1]),
        .sw2_i       (sw[2]),
        .mode_i      (mode),
        .btn_pause_i (btn),
        .sel_o       (sel),
        .led_o       (led),
        .step_o      (step),
        .paused_o    (paused)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit chg;
        bit pe;
        if (rst) begin
            m_mode_prev = 0;
            m_btn_prev  = 1'b0;
            m_manual    = 1'b1;
            m_paused    = 1'b0;
            m_pos       = 0;
            m_elapsed   = 0;
            m_k         = 0;
            m_step      = 1'b0;
            return;
        end
        chg    = (int'(mode) != m_mode_prev);
        pe     = btn && !m_btn_prev;
        m_step = 1'b0;
        if (chg) begin
            m_pos     = int'(sw);
            m_paused  = 1'b0;
            m_manual  = (mode == 2'b00);
            m_elapsed = 0;
            m_k       = int'(sw);
        end else if (m_manual) begin
            m_pos = int'(sw);
        end else if (!m_paused) begin
            m_elapsed++;
            if (m_elapsed == STEP_DIV) begin
                m_elapsed = 0;
                m_step    = 1'b1;
                case (mode)
                    2'b01:   m_pos = (m_pos + 1) % 8;
                    2'b10:   m_pos = (m_pos + 7) % 8;
                    default: begin
                        m_k   = (m_k + 1) % 14;
                        m_pos = (m_k <= 7) ? m_k : 14 - m_k;
                    end
                endcase
            end
            if (pe) m_paused = 1'b1;
        end else if (pe) begin
            m_paused = 1'b0;
        end
        m_mode_prev = int'(mode);
        m_btn_prev  = btn;
    endtask

    // One clock: update the model with the inputs seen at the edge, then
    // compare all outputs shortly after the edge.
    task automatic step_clk();
        @(posedge clk);
        model_edge();
        #1;
        check("sel",    8'(sel),    8'(m_pos));
        check("led",    led,        8'(1 << m_pos));
        check("step",   8'(step),   8'(m_step));
        check("paused", 8'(paused), 8'(m_paused));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step_clk();
        check("rst_sel", 8'(sel), 8'd0);
        check("rst_led", led, 8'h01);
        check("rst_step", 8'(step), 8'd0);
        check("rst_paused", 8'(paused), 8'd0);
        rst = 1'b0;

        // 1: manual sweep
        mode = 2'b00;
        for (int s = 0; s < 8; s++) begin
            sw = 3'(s);
            step_clk();
            check("s1_sel", 8'(sel), 8'(s));
            check("s1_led", led, 8'(1 << s));
            check("s1_step", 8'(step), 8'd0);
        end

        // 2: scan up from 5
        sw = 3'd5;
        step_clk();
        mode = 2'b01;
        step_clk();
        check("s2_load", 8'(sel), 8'd5);
        for (int i = 1; i <= 4; i++) begin
            repeat (3) begin
                step_clk();
                check("s2_nostep", 8'(step), 8'd0);
            end
            step_clk();
            check("s2_sel", 8'(sel), 8'((5 + i) % 8));
            check("s2_step", 8'(step), 8'd1);
        end

        // 3: ping-pong from 1
        mode = 2'b00;
        sw   = 3'd1;
        step_clk();
        mode = 2'b11;
        step_clk();
        check("s3_load", 8'(sel), 8'd1);
        for (int i = 0; i < 15; i++) begin
            repeat (3) step_clk();
            step_clk();
            check("s3_sel", 8'(sel), 8'(s3_seq[i]));
            check("s3_step", 8'(step), 8'd1);
        end

        // 4: pause / resume keeps the prescaler phase
        mode = 2'b00;
        sw   = 3'd3;
        step_clk();
        mode = 2'b01;
        step_clk();
        check("s4_load", 8'(sel), 8'd3);
        repeat (4) step_clk();
        check("s4_first", 8'(sel), 8'd4);
        step_clk();
        btn = 1'b1;
        step_clk();
        check("s4_paused", 8'(paused), 8'd1);
        repeat (10) step_clk();
        btn = 1'b0;
        repeat (10) step_clk();
        check("s4_hold_sel", 8'(sel), 8'd4);
        check("s4_hold_paused", 8'(paused), 8'd1);
        btn = 1'b1;
        step_clk();
        check("s4_resume", 8'(paused), 8'd0);
        step_clk();
        check("s4_wait", 8'(step), 8'd0);
        step_clk();
        check("s4_next_sel", 8'(sel), 8'd5);
        check("s4_next_step", 8'(step), 8'd1);

        // 5: mode change colliding with tick and pause edge
        btn  = 1'b0;
        sw   = 3'd6;
        mode = 2'b10;
        step_clk();
        check("s5_load", 8'(sel), 8'd6);
        repeat (3) step_clk();
        mode = 2'b01;
        btn  = 1'b1;
        sw   = 3'd2;
        step_clk();
        check("s5_sel", 8'(sel), 8'd2);
        check("s5_step", 8'(step), 8'd0);
        check("s5_paused", 8'(paused), 8'd0);
        repeat (3) step_clk();
        step_clk();
        check("s5_next_sel", 8'(sel), 8'd3);
        check("s5_next_step", 8'(step), 8'd1);

        // 6: reset mid-scan
        repeat (12) step_clk();
        check("s6_pre", 8'(sel), 8'd6);
        step_clk();
        rst = 1'b1;
        sw  = 3'd2;
        step_clk();
        check("s6_rst_sel", 8'(sel), 8'd0);
        check("s6_rst_led", led, 8'h01);
        check("s6_rst_paused", 8'(paused), 8'd0);
        rst = 1'b0;
        step_clk();
        check("s6_reload", 8'(sel), 8'd2);
        repeat (3) step_clk();
        step_clk();
        check("s6_step_sel", 8'(sel), 8'd3);
        check("s6_step", 8'(step), 8'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 40 == 0) mode = 2'($urandom);
            if ($urandom % 4 == 0)  sw   = 3'($urandom);
            if ($urandom % 12 == 0) btn  = ~btn;
            rst = ($urandom % 600 == 0);
            step_clk();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_led_scan_ctrl
`default_nettype wire

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Sequencer for the board's 8-LED one-hot bank. Generates the 3-bit LED select code either directly from the slide switches (manual) or autonomously as a timed scan: up, down or ping-pong. Decodes the code to a registered one-hot LED vector, with a push-button pause. Sits between the board switch/button inputs and the LED pins.

## Interface
- STEP_DIV, 50_000_000: clock cycles per scan step (≥1); 0.5 s at 100 MHz.
- CLK  in  1  board clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- SW0, SW1, SW2  in  1 each  manual code {SW2,SW1,SW0}; already synchronised upstream.
- MODE  in  2  00 manual, 01 scan up, 10 scan down, 11 ping-pong.
- BTN_PAUSE  in  1  level, debounced upstream; rising edge toggles pause.
- SEL  out  3  current LED code.
- LED  out  8  one-hot of SEL (LED[SEL]=1).
- STEP  out  1  one-cycle pulse when the scan position advances.
- PAUSED  out  1  high while the scan is held.

All outputs are registered.

## Operation
- MODE and BTN_PAUSE are registered internally as mode_q and btn_q. A mode change is MODE != mode_q; a pause edge is BTN_PAUSE & ~btn_q.
- States:
  - MANUAL: mode_q==00.
  - RUN: scanning.
  - HOLD: scan paused.
- Mode change to 00 → MANUAL, with PAUSED=0.
- Mode change to a scan mode (from any state) → RUN:
  - pos loaded from {SW2,SW1,SW0}.
  - dir = up for 01/11, down for 10.
  - Prescaler cleared to 0.
  - Pause cleared.
- MANUAL: SEL <= {SW2,SW1,SW0} every cycle; prescaler held at 0; pause edges ignored.
- RUN:
  - Prescaler counts 0..STEP_DIV-1 and wraps; tick is count==STEP_DIV-1.
  - On tick, pos advances and STEP=1 next cycle.
  - Up: 7→0 wraps.
  - Down: 0→7 wraps.
  - Ping-pong: dir flips at the ends with no double dwell (…6,7,6… and …1,0,1…).
- Pause edge in RUN → HOLD. Pause edge in HOLD → RUN.
- HOLD: prescaler frozen (not cleared), so resume continues the phase; pos frozen; PAUSED=1.
- Simultaneous events:
  - Mode change + pause edge: mode change wins, edge discarded.
  - Mode change + tick: mode change wins, no step.
  - Tick + pause edge in RUN: the step is taken, then HOLD.
- Prescaler width is $clog2(STEP_DIV), minimum 1. STEP_DIV=1 means tick every cycle in RUN.

## Timing
- Reset values:
  - SEL=0, LED=8'h01, STEP=0, PAUSED=0.
  - mode_q=00, btn_q=0, state MANUAL, prescaler 0, dir up.
- RST mid-scan: all of the above restored on the next edge. If MODE≠00 after reset, the first post-reset cycle is a mode change and loads pos from the switches.
- Manual latency: a switch change appears on SEL/LED one cycle later.
- Scan step timing:
  - Mode change sampled at edge k: SEL=switch code from k.
  - First step at edge k+STEP_DIV, then every STEP_DIV cycles while in RUN.
  - STEP high exactly in the cycle the new SEL is first visible.
- Pause: the pause edge is registered at edge p. PAUSED=1 from p.
- Resume at edge r: the remaining count from pause time elapses before the next step.
- LED always equals the one-hot of SEL in the same cycle; never zero and never multi-hot.

## Structure
- Shared package led_ctrl_pkg holds:
  - MODE encodings: MODE_MANUAL, MODE_UP, MODE_DOWN, MODE_PING.
  - State enum: ST_MANUAL, ST_RUN, ST_HOLD.
- One sub-module, step_tick, is the prescaler.
  - Parameter: STEP_DIV.
  - Inputs: CLK, RST, clr, en.
  - Output: tick.
  - clr has priority over en.
- FSM, position/direction logic and the one-hot decode live in led_scan_ctrl.

## Test plan
All scenarios use STEP_DIV=4.
1. Reset, then hold MODE=00 and sweep switches 0..7 → SEL follows with 1-cycle lag; LED=8'h01,02,…,80; STEP never high.
2. Switches=5, MODE 00→01 → SEL=5, then 6,7,0,1 at 4-cycle spacing; STEP pulses once per step.
3. Switches=1, MODE=11 → SEL sequence 1,2,…,7,6,5,…,0,1,2; 7 and 0 each dwell exactly one step.
4. MODE=01 from 3; pause edge 2 cycles after a step; hold 20 cycles; release and press again → PAUSED=1 and SEL stays 4 during hold; after resume the next step comes 2 cycles later (5).
5. In MODE=10, change MODE to 01 on the same cycle as a tick and a pause edge → no step, PAUSED=0, pos reloaded from switches, next step 4 cycles later, incrementing.
6. Assert RST for one cycle mid-scan at SEL=6 with MODE=01 and switches=2 → outputs at reset values. Next cycle SEL=2 (mode-change reload), then steps to 3 after 4 cycles.
